// File: rtl/uart_rx_core.sv
// UART receive engine: synchronizes the serial line, deserializes one frame per
// the latched LCR settings and hands the word out over valid/ready. Define
// UART_RX_BREAK_DET_EN to add break detection (break_o output and BREAK state).
module uart_rx_core #(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [1:0]            wls_i,
  input  logic                  pen_i,
  input  logic [1:0]            ps_i,
  input  logic                  stb_i,
  input  logic                  uart_rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  pe_o,
  output logic                  fe_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  busy_o,
  output logic                  break_o
`else
  output logic                  busy_o
`endif
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

`ifdef UART_RX_BREAK_DET_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;
`endif

  // Valid/ready: a word is transferred on any rising clock edge where valid_o
  // and ready_i are both high; valid_o and its data/pe/fe stay stable until then.

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [DIV_WIDTH-1:0]  w_cnt_nxt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  w_div_eff;
  logic [1:0]            r_wls;
  logic [1:0]            r_ps;
  logic                  r_pen;
  logic                  r_stb;
  logic [2:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_pe;
  logic                  r_fe;
  logic                  r_par_bit;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_pe_out;
  logic                  r_fe_out;
  logic                  r_valid;
  logic                  r_overrun;

  logic                  w_sample;
  logic                  w_fall;
  logic                  w_tick;
  logic [2:0]            w_last_idx;
  logic                  w_par_exp;
  logic                  w_latch;
  logic                  w_shift;
  logic                  w_par_chk;
  logic                  w_stop_chk;
  logic                  w_complete;
`ifdef UART_RX_BREAK_DET_EN
  logic                  r_break;
  logic                  w_brk_hit;
  logic                  w_is_break;
`endif

  assign w_sample   = r_sync2;
  assign w_fall     = r_prev & ~r_sync2;
  assign w_tick     = (r_cnt == '0);
  assign w_div_eff  = (div_i < DIV_MIN) ? DIV_MIN : div_i;
  assign w_last_idx = {1'b0, r_wls} + 3'd4;

  // Bits above the word length stay zero, so the full-width XOR is the data XOR.
  always_comb begin
    w_par_exp = 1'b0;
    case (r_ps)
      2'b00:   w_par_exp = ^r_shift;
      2'b01:   w_par_exp = ~(^r_shift);
      2'b10:   w_par_exp = 1'b1;
      default: w_par_exp = 1'b0;
    endcase
  end

`ifdef UART_RX_BREAK_DET_EN
  assign w_is_break = (r_shift == '0) && !r_par_bit && !w_sample;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_shift     = 1'b0;
    w_par_chk   = 1'b0;
    w_stop_chk  = 1'b0;
    w_complete  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    w_brk_hit   = 1'b0;
`endif
    if (!en_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = w_div_eff >> 1;
            w_latch     = 1'b1;
          end
        end
        S_START: begin
          if (!w_tick) begin
            w_cnt_nxt = r_cnt - DIV_ONE;
          end else if (w_sample) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = r_div - DIV_ONE;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            w_cnt_nxt = r_cnt - DIV_ONE;
          end else begin
            w_shift   = 1'b1;
            w_cnt_nxt = r_div - DIV_ONE;
            if (r_bit_cnt == w_last_idx) begin
              w_state_nxt = r_pen ? S_PARITY : S_STOP1;
            end
          end
        end
        S_PARITY: begin
          if (!w_tick) begin
            w_cnt_nxt = r_cnt - DIV_ONE;
          end else begin
            w_par_chk   = 1'b1;
            w_cnt_nxt   = r_div - DIV_ONE;
            w_state_nxt = S_STOP1;
          end
        end
        S_STOP1: begin
          if (!w_tick) begin
            w_cnt_nxt = r_cnt - DIV_ONE;
          end else begin
            w_stop_chk = 1'b1;
            w_cnt_nxt  = r_div - DIV_ONE;
`ifdef UART_RX_BREAK_DET_EN
            if (w_is_break) begin
              w_brk_hit   = 1'b1;
              w_state_nxt = S_BREAK;
            end else
`endif
            if (r_stb) begin
              w_state_nxt = S_STOP2;
            end else begin
              w_complete  = 1'b1;
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end
          end
        end
        S_STOP2: begin
          if (!w_tick) begin
            w_cnt_nxt = r_cnt - DIV_ONE;
          end else begin
            w_stop_chk  = 1'b1;
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        // Any low sample restarts the full-period wait for a released line.
        S_BREAK: begin
          if (!w_sample) begin
            w_cnt_nxt = r_div - DIV_ONE;
          end else if (w_tick) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - DIV_ONE;
          end
        end
`endif
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_prev    <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_wls     <= '0;
      r_ps      <= '0;
      r_pen     <= 1'b0;
      r_stb     <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_par_bit <= 1'b0;
      r_data    <= '0;
      r_pe_out  <= 1'b0;
      r_fe_out  <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_break   <= 1'b0;
`endif
    end else begin
      r_sync1   <= uart_rx_i;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_break   <= w_brk_hit;
`endif
      if (w_latch) begin
        r_div     <= w_div_eff;
        r_wls     <= wls_i;
        r_ps      <= ps_i;
        r_pen     <= pen_i;
        r_stb     <= stb_i;
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_pe      <= 1'b0;
        r_fe      <= 1'b0;
        r_par_bit <= 1'b0;
      end
      if (w_shift) begin
        r_shift[r_bit_cnt] <= w_sample;
        r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
      if (w_par_chk) begin
        r_par_bit <= w_sample;
        if (w_sample != w_par_exp) r_pe <= 1'b1;
      end
      if (w_stop_chk && !w_sample) r_fe <= 1'b1;

      if (r_valid && ready_i) r_valid <= 1'b0;
      // A completing frame may replace the held word only if it leaves this cycle.
      if (w_complete) begin
        if (!r_valid || ready_i) begin
          r_data   <= r_shift;
          r_pe_out <= r_pe;
          r_fe_out <= r_fe | ~w_sample;
          r_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign data_o    = r_data;
  assign pe_o      = r_pe_out;
  assign fe_o      = r_fe_out;
  assign valid_o   = r_valid;
  assign overrun_o = r_overrun;
  assign busy_o    = (r_state != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign break_o   = r_break;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames from the test plan, then randomized
// frames scored against a frame-level reference model through an expected queue.
module tb_uart_rx_core;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic [15:0] div_i = 16'd16;
  logic [1:0] wls_i = 2'b11;
  logic       pen_i = 1'b0;
  logic [1:0] ps_i = 2'b00;
  logic       stb_i = 1'b0;
  logic       uart_rx_i = 1'b1;
  logic [7:0] data_o;
  logic       pe_o;
  logic       fe_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic       overrun_o;
  logic       busy_o;
`ifdef UART_RX_BREAK_DET_EN
  logic       break_o;
`endif

  uart_rx_core #(.DIV_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .div_i     (div_i),
    .wls_i     (wls_i),
    .pen_i     (pen_i),
    .ps_i      (ps_i),
    .stb_i     (stb_i),
    .uart_rx_i (uart_rx_i),
    .data_o    (data_o),
    .pe_o      (pe_o),
    .fe_o      (fe_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o),
`ifdef UART_RX_BREAK_DET_EN
    .busy_o    (busy_o),
    .break_o   (break_o)
`else
    .busy_o    (busy_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad = 0;
  int ovr_seen = 0;
  int brk_seen = 0;
  int brk_exp = 0;
  bit mon_on = 1'b0;
  bit rand_ready = 1'b0;
  logic [9:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected {pe, fe, data} for a frame, or a break event.
  task automatic model_frame(input logic [7:0] w, input logic pen, input logic sent_par,
                             input logic par_ok, input logic stb, input logic s1,
                             input logic s2);
    logic pe_e;
    logic fe_e;
    pe_e = pen && !par_ok;
    fe_e = !s1 || (stb && !s2);
`ifdef UART_RX_BREAK_DET_EN
    if (w == 8'h00 && (!pen || !sent_par) && !s1) begin
      brk_exp++;
      return;
    end
`endif
    exp_q.push_back({pe_e, fe_e, w});
  endtask

  // driver: one complete frame, each bit held for div cycles
  task automatic send_frame(input logic [7:0] d, input int div, input logic [1:0] wls,
                            input logic pen, input logic [1:0] ps, input logic stb,
                            input logic par_flip, input logic s1, input logic s2,
                            input logic scramble, input logic push);
    int n;
    int ones;
    logic [7:0] w;
    logic ep;
    logic sp;
    n = 5 + int'(wls);
    w = d & 8'((1 << n) - 1);
    ones = $countones(w);
    case (ps)
      2'b00:   ep = (ones % 2) == 1;
      2'b01:   ep = (ones % 2) == 0;
      2'b10:   ep = 1'b1;
      default: ep = 1'b0;
    endcase
    sp = ep ^ par_flip;
    if (push) model_frame(w, pen, sp, !par_flip, stb, s1, s2);
    div_i = 16'(div); wls_i = wls; pen_i = pen; ps_i = ps; stb_i = stb;
    uart_rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    if (scramble) begin
      div_i = 16'($urandom_range(0, 40)); wls_i = 2'($urandom); pen_i = 1'($urandom);
      ps_i = 2'($urandom); stb_i = 1'($urandom);
    end
    repeat (div - 3) @(negedge clk_i);
    for (int i = 0; i < n; i++) begin
      uart_rx_i = w[i];
      repeat (div) @(negedge clk_i);
    end
    if (pen) begin
      uart_rx_i = sp;
      repeat (div) @(negedge clk_i);
    end
    uart_rx_i = s1;
    repeat (div) @(negedge clk_i);
    if (stb) begin
      uart_rx_i = s2;
      repeat (div) @(negedge clk_i);
    end
    uart_rx_i = 1'b1;
  endtask

  task automatic accept_word();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  // randomized consumer, changing ready away from both clock edges
  always @(posedge clk_i) begin
    #2;
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
  end

  // scoreboard: pop on each accepted word; held words must stay stable
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [9:0] prev_w = '0;
  always @(negedge clk_i) begin
    if (overrun_o) ovr_seen++;
`ifdef UART_RX_BREAK_DET_EN
    if (break_o) brk_seen++;
`endif
    if (mon_on && !rst_i) begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", {31'd0, valid_o}, 32'd1);
        chk("hold_word", {22'd0, pe_o, fe_o, data_o}, {22'd0, prev_w});
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("spurious_word", 32'd1, 32'd0);
        else chk("rx_word", {22'd0, pe_o, fe_o, data_o}, {22'd0, exp_q.pop_front()});
      end
    end
    prev_v = valid_o;
    prev_r = ready_i;
    prev_w = {pe_o, fe_o, data_o};
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    int ovr_base;
    int brk_base;
    int busy_cnt;
    int seen_v;
    int dv;
    logic [7:0] d;
    logic [1:0] wl;
    logic [1:0] ps;
    logic pen;
    logic stb;
    logic pf;
    logic s1;
    logic s2;

    repeat (4) @(negedge clk_i);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_flags", {29'd0, pe_o, fe_o, overrun_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    en_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // 8N1 0xA5 at div 16
    send_frame(8'hA5, 16, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("a5_valid", {31'd0, valid_o}, 32'd1);
    chk("a5_word", {22'd0, pe_o, fe_o, data_o}, {22'd0, 2'b00, 8'hA5});
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk("a5_clear", {31'd0, valid_o}, 32'd0);
    repeat (4) @(negedge clk_i);

    // 5-bit odd parity, wrong parity bit sent (0x13 has three ones: correct bit is 0)
    send_frame(8'h13, 8, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_word", {22'd0, pe_o, fe_o, data_o}, {22'd0, 2'b10, 8'h13});
    accept_word();
    repeat (4) @(negedge clk_i);

    // two stop bits, second one low
    send_frame(8'h3C, 10, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stop2_word", {22'd0, pe_o, fe_o, data_o}, {22'd0, 2'b01, 8'h3C});
    accept_word();
    repeat (20) @(negedge clk_i);

    // overrun: second frame dropped while 0x11 is held
    ovr_base = ovr_seen;
    send_frame(8'h11, 8, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 8, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk_i);
    chk("ovr_data", {24'd0, data_o}, 32'h11);
    chk("ovr_count", 32'(ovr_seen - ovr_base), 32'd1);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk("ovr_clear", {31'd0, valid_o}, 32'd0);
    repeat (4) @(negedge clk_i);

    // 3-cycle glitch at div 16
    div_i = 16'd16;
    uart_rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    uart_rx_i = 1'b1;
    busy_cnt = 0;
    seen_v = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
      if (valid_o) seen_v++;
    end
    chk("glitch_busy", {31'd0, (busy_cnt >= 8 && busy_cnt <= 12)}, 32'd1);
    chk("glitch_novalid", 32'(seen_v), 32'd0);

    // break: ten low bit times at div 4
    brk_base = brk_seen;
    div_i = 16'd4; wls_i = 2'b11; pen_i = 1'b0; stb_i = 1'b0;
    uart_rx_i = 1'b0;
    repeat (40) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (25) @(negedge clk_i);
`ifdef UART_RX_BREAK_DET_EN
    chk("brk_pulse", 32'(brk_seen - brk_base), 32'd1);
    chk("brk_novalid", {31'd0, valid_o}, 32'd0);
    chk("brk_idle", {31'd0, busy_o}, 32'd0);
`else
    chk("brk_valid", {31'd0, valid_o}, 32'd1);
    chk("brk_word", {22'd0, pe_o, fe_o, data_o}, {22'd0, 2'b01, 8'h00});
    accept_word();
`endif
    repeat (4) @(negedge clk_i);

    // enable drop mid-frame keeps a pending word
    ovr_base = ovr_seen;
    send_frame(8'h5A, 8, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    uart_rx_i = 1'b0;
    repeat (16) @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    chk("en_abort_busy", {31'd0, busy_o}, 32'd0);
    repeat (10) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (10) @(negedge clk_i);
    en_i = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("en_hold", {23'd0, valid_o, data_o}, {23'd0, 1'b1, 8'h5A});
    chk("en_no_ovr", 32'(ovr_seen - ovr_base), 32'd0);
    accept_word();

    // reset in mid-frame with a pending word
    send_frame(8'h77, 8, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    uart_rx_i = 1'b0;
    repeat (11) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_outputs", {22'd0, valid_o, pe_o, fe_o, overrun_o, busy_o, 5'd0} |
        {24'd0, data_o}, 32'd0);
    rst_i = 1'b0;
    uart_rx_i = 1'b1;
    repeat (10) @(negedge clk_i);

    // randomized frames against the model
    ovr_base = ovr_seen;
    brk_base = brk_seen;
    mon_on = 1'b1;
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      dv  = $urandom_range(4, 20);
      d   = 8'($urandom);
      wl  = 2'($urandom);
      pen = 1'($urandom);
      ps  = 2'($urandom);
      stb = 1'($urandom);
      pf  = pen ? 1'($urandom) : 1'b0;
      s1  = ($urandom_range(0, 7) != 0);
      s2  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) begin
        d = 8'h00;
        s1 = 1'b0;
      end
      send_frame(d, dv, wl, pen, ps, stb, pf, s1, s2, 1'b1, 1'b1);
      if (!s1 || !s2) repeat (2 * dv + 6) @(negedge clk_i);
      else repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk_i);
    rand_ready = 1'b0;
    @(negedge clk_i);
    mon_on = 1'b0;
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    chk("rand_no_ovr", 32'(ovr_seen - ovr_base), 32'd0);
`ifdef UART_RX_BREAK_DET_EN
    chk("rand_breaks", 32'(brk_seen - brk_base), 32'(brk_exp));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
